// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: data width, default vectors, FSM encoding.
package fetch_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned WEN_W    = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] EXCP_PC_DEF  = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fs_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction SRAM request bus between the fetch stage and the synchronous SRAM.
//   inst_sram_en    : read enable
//   inst_sram_wen   : byte write enables (fetch never writes)
//   inst_sram_addr  : fetch address
//   inst_sram_wdata : write data (fetch never writes)
// master = fetch stage (drives the request), slave = SRAM.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic             inst_sram_en;
    logic [WEN_W-1:0] inst_sram_wen;
    logic [XLEN-1:0]  inst_sram_addr;
    logic [XLEN-1:0]  inst_sram_wdata;

    modport master (
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues reads to the 1-cycle
// synchronous instruction SRAM and presents the PC aligned with the returning
// read data. pc = 0 marks a bubble for the decoder.
//   clk, reset  : clock, synchronous active-high reset
//   stall       : backend stall, hold all fetch state
//   br_e/br_addr: branch redirect and target
//   excp_e      : exception redirect to EXCP_PC (beats br_e)
//   sram        : SRAM request bus (master side)
//   pc          : PC of the instruction whose data is on the SRAM rdata pins
//   fetch_adel  : pc is misaligned (address error on fetch)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXCP_PC  = EXCP_PC_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 br_e,
    input  logic [XLEN-1:0]      br_addr,
    input  logic                 excp_e,
    fetch_stage_if.master        sram,
    output logic [XLEN-1:0]      pc,
    output logic                 fetch_adel
);

    fs_state_e       state,    state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] pc_r,     pc_nxt;
    logic            adel_r,   adel_nxt;

    // State and fetch registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FS_IDLE;
            fetch_pc <= RESET_PC;
            pc_r     <= '0;
            adel_r   <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pc_r     <= pc_nxt;
            adel_r   <= adel_nxt;
        end
    end

    // Next-state: redirects override stall; stall freezes everything.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pc_nxt       = pc_r;
        adel_nxt     = adel_r;

        if (excp_e) begin
            state_nxt    = FS_RUN;
            fetch_pc_nxt = EXCP_PC;
            pc_nxt       = '0;
            adel_nxt     = 1'b0;
        end else if (br_e) begin
            state_nxt    = FS_RUN;
            fetch_pc_nxt = br_addr;
            pc_nxt       = '0;
            adel_nxt     = 1'b0;
        end else if (!stall) begin
            unique case (state)
                FS_IDLE: begin
                    state_nxt = FS_RUN;
                    pc_nxt    = '0;
                    adel_nxt  = 1'b0;
                end
                FS_RUN: begin
                    pc_nxt   = fetch_pc;
                    adel_nxt = |fetch_pc[1:0];
                    // A misaligned fetch is issued once, then fetch parks until redirected.
                    if (|fetch_pc[1:0]) begin
                        state_nxt = FS_HALT;
                    end else begin
                        fetch_pc_nxt = fetch_pc + XLEN'(4);
                    end
                end
                FS_HALT: begin
                    pc_nxt   = '0;
                    adel_nxt = 1'b0;
                end
                default: begin
                    state_nxt = FS_IDLE;
                end
            endcase
        end
    end

    assign sram.inst_sram_en    = (state == FS_RUN) & ~reset;
    assign sram.inst_sram_wen   = '0;
    assign sram.inst_sram_addr  = fetch_pc;
    assign sram.inst_sram_wdata = '0;

    assign pc         = pc_r;
    assign fetch_adel = adel_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset sequence, streaming, stall hold,
// branch/exception redirect, misaligned-fetch halt, PC wrap and mid-run reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic            clk;
    logic            reset;
    logic            stall;
    logic            br_e;
    logic [31:0]     br_addr;
    logic            excp_e;
    logic [31:0]     pc;
    logic            fetch_adel;

    int unsigned     n_checks;
    int unsigned     n_errors;

    fetch_stage_if sram_if ();

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_e       (br_e),
        .br_addr    (br_addr),
        .excp_e     (excp_e),
        .sram       (sram_if),
        .pc         (pc),
        .fetch_adel (fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic en, input logic [31:0] addr,
                              input logic [31:0] pc_exp, input logic adel);
        check({tag, ".en"},   32'(sram_if.inst_sram_en), 32'(en));
        check({tag, ".addr"}, sram_if.inst_sram_addr,    addr);
        check({tag, ".pc"},   pc,                        pc_exp);
        check({tag, ".adel"}, 32'(fetch_adel),           32'(adel));
    endtask

    // Release reset and walk the first two fetches.
    task automatic reset_release(input string tag);
        reset = 1'b0;
        expect_out({tag, "_c1"}, 1'b0, 32'hBFC0_0000, 32'h0, 1'b0);
        step();
        expect_out({tag, "_c2"}, 1'b1, 32'hBFC0_0000, 32'h0, 1'b0);
        step();
        expect_out({tag, "_c3"}, 1'b1, 32'hBFC0_0004, 32'hBFC0_0000, 1'b0);
        step();
        expect_out({tag, "_c4"}, 1'b1, 32'hBFC0_0008, 32'hBFC0_0004, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        stall    = 1'b0;
        br_e     = 1'b0;
        br_addr  = 32'h0;
        excp_e   = 1'b0;

        // Held in reset: no fetch, bubble on pc, write side tied off.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("rst", 1'b0, 32'hBFC0_0000, 32'h0, 1'b0);
        end
        check("rst.wen",   32'(sram_if.inst_sram_wen), 32'h0);
        check("rst.wdata", sram_if.inst_sram_wdata,    32'h0);

        reset_release("boot");
        step();
        expect_out("stream", 1'b1, 32'hBFC0_000C, 32'hBFC0_0008, 1'b0);

        // Three stalled edges hold everything.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("stall_hold", 1'b1, 32'hBFC0_000C, 32'hBFC0_0008, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_out("stall_rel", 1'b1, 32'hBFC0_0010, 32'hBFC0_000C, 1'b0);
        step();
        expect_out("stall_next", 1'b1, 32'hBFC0_0014, 32'hBFC0_0010, 1'b0);

        // Branch redirect in RUN.
        br_e = 1'b1; br_addr = 32'hBFC0_0100;
        step();
        br_e = 1'b0; br_addr = 32'h0;
        expect_out("br", 1'b1, 32'hBFC0_0100, 32'h0, 1'b0);
        step();
        expect_out("br_tgt", 1'b1, 32'hBFC0_0104, 32'hBFC0_0100, 1'b0);

        // Branch coinciding with stall is taken immediately.
        stall = 1'b1; br_e = 1'b1; br_addr = 32'hBFC0_0100;
        step();
        stall = 1'b0; br_e = 1'b0; br_addr = 32'h0;
        expect_out("br_stall", 1'b1, 32'hBFC0_0100, 32'h0, 1'b0);
        step();
        expect_out("br_stall_tgt", 1'b1, 32'hBFC0_0104, 32'hBFC0_0100, 1'b0);

        // Exception beats branch.
        excp_e = 1'b1; br_e = 1'b1; br_addr = 32'hBFC0_0200;
        step();
        excp_e = 1'b0; br_e = 1'b0; br_addr = 32'h0;
        expect_out("excp", 1'b1, 32'hBFC0_0380, 32'h0, 1'b0);
        step();
        expect_out("excp_tgt", 1'b1, 32'hBFC0_0384, 32'hBFC0_0380, 1'b0);

        // Misaligned target: one flagged fetch, then halt until redirected.
        br_e = 1'b1; br_addr = 32'hBFC0_0102;
        step();
        br_e = 1'b0; br_addr = 32'h0;
        expect_out("adel_issue", 1'b1, 32'hBFC0_0102, 32'h0, 1'b0);
        step();
        expect_out("adel_flag", 1'b0, 32'hBFC0_0102, 32'hBFC0_0102, 1'b1);
        step();
        expect_out("halt1", 1'b0, 32'hBFC0_0102, 32'h0, 1'b0);
        step();
        expect_out("halt2", 1'b0, 32'hBFC0_0102, 32'h0, 1'b0);
        br_e = 1'b1; br_addr = 32'hBFC0_0200;
        step();
        br_e = 1'b0; br_addr = 32'h0;
        expect_out("halt_br", 1'b1, 32'hBFC0_0200, 32'h0, 1'b0);
        step();
        expect_out("halt_resume", 1'b1, 32'hBFC0_0204, 32'hBFC0_0200, 1'b0);

        // PC wraps modulo 2^32; pc=0 then reads as a bubble.
        br_e = 1'b1; br_addr = 32'hFFFF_FFFC;
        step();
        br_e = 1'b0; br_addr = 32'h0;
        step();
        expect_out("wrap_top", 1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b0);
        step();
        expect_out("wrap_zero", 1'b1, 32'h0000_0004, 32'h0, 1'b0);

        // Reset mid-stream.
        reset = 1'b1;
        step();
        expect_out("rst_run", 1'b0, 32'hBFC0_0000, 32'h0, 1'b0);
        reset_release("rerun");

        // Reset mid-stall.
        stall = 1'b1;
        step();
        expect_out("pre_rst_stall", 1'b1, 32'hBFC0_0008, 32'hBFC0_0004, 1'b0);
        reset = 1'b1;
        step();
        stall = 1'b0;
        expect_out("rst_stall", 1'b0, 32'hBFC0_0000, 32'h0, 1'b0);
        reset_release("restall");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the fetch PC and drives the synchronous instruction SRAM (1-cycle read latency).
- Presents {pc, inst_sram_rdata} aligned so the decoder samples both on the same edge.
- Handles stall hold, branch redirect, exception redirect and misaligned-fetch halt; pc = 0 is the bubble marker the decoder treats as invalid.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
EXCP_PC, 32'hBFC0_0380, redirect target on excp_e

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall  in  1  backend stall; hold fetch state
br_e  in  1  branch redirect (resolved branch, delay slot already handled)
br_addr  in  32  branch target
excp_e  in  1  exception flush/redirect to EXCP_PC
inst_sram_en  out  1  SRAM read enable
inst_sram_wen  out  4  tied 4'b0
inst_sram_addr  out  32  fetch address (= fetch_pc)
inst_sram_wdata  out  32  tied 32'b0
pc  out  32  PC of the instruction whose data is on inst_sram_rdata this cycle; 0 = bubble
fetch_adel  out  1  pc is misaligned (address-error-on-fetch); qualifies pc

Behaviour:
- Single clock domain; clk with synchronous active-high reset, as already decided.
- Registers: fetch_pc[31:0], pc_r[31:0], adel_r, state[1:0].
- Reset values: fetch_pc=RESET_PC, pc_r=0, adel_r=0, state=IDLE. Outputs during reset: inst_sram_en=0, pc=0, fetch_adel=0.
- FSM states:
  - IDLE: one cycle after reset release; en=0; then RUN.
  - RUN: en=1.
  - HALT: en=0; entered after a misaligned fetch_pc has been issued into pc_r.
- Per-edge priority: reset > excp_e > br_e > stall > normal.
  - excp_e: fetch_pc<=EXCP_PC; pc_r<=0; adel_r<=0; state<=RUN (from any state, including IDLE/HALT).
  - br_e: fetch_pc<=br_addr; pc_r<=0; adel_r<=0; state<=RUN.
  - Simultaneous excp_e and br_e: excp_e wins; br_addr is ignored.
  - stall (no redirect): all registers hold. SRAM address is held, so rdata may not match pc; the decoder ignores the pins while stalled. Redirect during stall is taken immediately and is not deferred.
  - Normal in RUN: pc_r<=fetch_pc; adel_r<=|fetch_pc[1:0]; fetch_pc<=fetch_pc+4.
    - If fetch_pc[1:0]!=0: fetch_pc holds and state<=HALT.
    - inst_sram_en is still asserted on that cycle; the read data is garbage and is qualified by fetch_adel.
  - Normal in HALT: pc_r<=0; adel_r<=0; remain HALT until a redirect.
- Redirect latency: target data is on the pins 2 cycles after the br_e/excp_e edge. pc=0 exactly one cycle after a redirect, which masks the wrong-path SRAM return.
- Stall release: the first non-stalled edge loads pc_r with the held fetch_pc. The instruction after the decoder-buffered one appears on the pins one cycle after release, with no duplicate or lost instruction.
- Arithmetic: fetch_pc+4 is modulo 2^32. 0xFFFF_FFFC wraps to 0 with no special handling, and pc=0 then reads as a bubble downstream.
- inst_sram_addr = fetch_pc, combinational from the register. inst_sram_en = (state==RUN) & ~reset.

Decomposition:
- Shared package/defines.vh: RESET_PC, EXCP_PC defaults, FSM state encodings (FS_IDLE=0, FS_RUN=1, FS_HALT=2).
- No sub-module needed. The next-PC mux may be a local function; a separate pc_gen is unjustified at this size.

Test Plan:
- Reset release → cycle1 en=0, cycle2 addr=BFC00000 en=1, cycle3 pc=BFC00000, cycle4 pc=BFC00004; pc=0 throughout reset.
- Streaming with stall high for 3 cycles after pc=BFC00008 → pc stays BFC00008 and addr stays BFC0000C during stall. First edge after release gives pc=BFC0000C; no PC skipped or repeated.
- br_e with br_addr=BFC00100 in RUN → next cycle addr=BFC00100, pc=0; following cycle pc=BFC00100. Same result when br_e coincides with stall.
- excp_e and br_e (br_addr=BFC00200) in the same cycle → addr=BFC00380, pc=0, then pc=BFC00380.
- br_addr=BFC00102 → pc=BFC00102 with fetch_adel=1 for one cycle, then en=0 and pc=0 in HALT. Subsequent br_e to BFC00200 resumes with pc=BFC00200 and fetch_adel=0.
- Reset asserted mid-stream and mid-stall → next edge pc=0, fetch_pc=RESET_PC, state=IDLE; sequence restarts as in scenario 1.
